// File: rtl/mac_hdr_extract.sv
// mac_hdr_extract: parses DA (bytes 0-5) and SA (bytes 6-11) from the head of
// each ingress frame, XOR-folds each MAC into a pADDR_WIDTH hash, issues one
// learn/lookup request and forwards the lookup result (or a timeout miss).
// Build option: MAC_HDR_MCAST_SA_DROP_EN drops frames whose SA has the I/G bit set.
module mac_hdr_extract #(
  parameter int pNUM_PORTS  = 4,
  parameter int pADDR_WIDTH = 14,
  parameter int pWAIT_MAX   = 16
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic [7:0]                    idata,
  input  logic                          ivalid,
  input  logic                          isof,
  input  logic                          ieof,
  input  logic [$clog2(pNUM_PORTS)-1:0] iport,
  output logic [$clog2(pNUM_PORTS)-1:0] opnum,
  output logic [pADDR_WIDTH-1:0]        osa,
  output logic [pADDR_WIDTH-1:0]        oda,
  output logic                          owr_en,
  input  logic                          ilk_ready,
  input  logic [$clog2(pNUM_PORTS)-1:0] ilk_pnum,
  output logic                          olk_valid,
  output logic [$clog2(pNUM_PORTS)-1:0] olk_pnum,
  output logic [$clog2(pNUM_PORTS)-1:0] olk_src,
  output logic                          olk_miss,
  output logic [7:0]                    odrop_cnt
);

  localparam int PW  = $clog2(pNUM_PORTS);
  localparam int W   = pADDR_WIDTH;
  localparam int NCH = (48 + W - 1) / W;
  localparam int TW  = $clog2(pWAIT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DA,
    S_SA,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      byte_cnt;
  logic [47:0]     da_mac;
  logic [39:0]     sa_mac;
  logic [PW-1:0]   src_port;
  logic [PW-1:0]   req_port;
  logic [W-1:0]    sa_hash, da_hash;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   lk_pnum;
  logic            lk_miss_r;
  logic [7:0]      drop_cnt;
  logic [8:0]      drop_sum;

  logic            cap_sof;
  logic            cap_byte;
  logic            load_req;
  logic            lk_hit;
  logic            lk_timeout;
  logic [1:0]      drop_inc;
  logic            busy_sof;

  // XOR of consecutive W-bit chunks of the MAC, upper chunk zero-extended
  function automatic logic [W-1:0] fold_mac(input logic [47:0] mac);
    logic [NCH*W-1:0] ext;
    logic [W-1:0]     h;
    ext = (NCH*W)'(mac);
    h   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      h ^= ext[k*W +: W];
    end
    return h;
  endfunction

  assign busy_sof = ivalid & isof;

  // State register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-beat control decode
  always_comb begin
    state_nxt  = state;
    cap_sof    = 1'b0;
    cap_byte   = 1'b0;
    load_req   = 1'b0;
    lk_hit     = 1'b0;
    lk_timeout = 1'b0;
    drop_inc   = 2'd0;
    case (state)
      S_IDLE: begin
        if (ivalid && isof) begin
          if (ieof) drop_inc = 2'd1;
          else begin
            cap_sof   = 1'b1;
            state_nxt = S_DA;
          end
        end
      end
      S_DA, S_SA: begin
        if (ivalid) begin
          if (isof) begin
            // Abandoned frame counts once; a new frame that is also a
            // single-beat runt counts again.
            if (ieof) begin
              drop_inc  = 2'd2;
              state_nxt = S_IDLE;
            end else begin
              drop_inc  = 2'd1;
              cap_sof   = 1'b1;
              state_nxt = S_DA;
            end
          end else begin
            cap_byte = 1'b1;
            if (byte_cnt == 4'd11) begin
              load_req  = 1'b1;
              state_nxt = S_REQ;
`ifdef MAC_HDR_MCAST_SA_DROP_EN
              // sa_mac still holds bytes 6-10 here, so byte 6 bit 0 is [32]
              if (sa_mac[32]) begin
                load_req  = 1'b0;
                drop_inc  = 2'd1;
                state_nxt = S_IDLE;
              end
`endif
            end else if (ieof) begin
              drop_inc  = 2'd1;
              state_nxt = S_IDLE;
            end else if (byte_cnt == 4'd5) begin
              state_nxt = S_SA;
            end
          end
        end
      end
      S_REQ: begin
        if (busy_sof) drop_inc = 2'd1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (busy_sof) drop_inc = 2'd1;
        if (ilk_ready) begin
          lk_hit    = 1'b1;
          state_nxt = S_RESP;
        end else if (timer == TW'(pWAIT_MAX - 1)) begin
          lk_timeout = 1'b1;
          state_nxt  = S_RESP;
        end
      end
      S_RESP: begin
        if (busy_sof) drop_inc = 2'd1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  // Header capture, request latching, lookup result and drop counting
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      byte_cnt  <= '0;
      da_mac    <= '0;
      sa_mac    <= '0;
      src_port  <= '0;
      req_port  <= '0;
      sa_hash   <= '0;
      da_hash   <= '0;
      timer     <= '0;
      lk_pnum   <= '0;
      lk_miss_r <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (cap_sof) begin
        da_mac   <= {da_mac[39:0], idata};
        src_port <= iport;
        byte_cnt <= 4'd1;
      end else if (cap_byte) begin
        if (state == S_DA) da_mac <= {da_mac[39:0], idata};
        else               sa_mac <= {sa_mac[31:0], idata};
        byte_cnt <= byte_cnt + 4'd1;
      end

      if (load_req) begin
        da_hash  <= fold_mac(da_mac);
        sa_hash  <= fold_mac({sa_mac, idata});
        req_port <= src_port;
      end

      timer <= (state == S_WAIT) ? timer + 1'b1 : '0;

      if (lk_hit) begin
        lk_pnum   <= ilk_pnum;
        lk_miss_r <= 1'b0;
      end else if (lk_timeout) begin
        lk_pnum   <= '0;
        lk_miss_r <= 1'b1;
      end

      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign owr_en    = (state == S_REQ);
  assign olk_valid = (state == S_RESP);
  assign opnum     = req_port;
  assign olk_src   = req_port;
  assign osa       = sa_hash;
  assign oda       = da_hash;
  assign olk_pnum  = lk_pnum;
  assign olk_miss  = lk_miss_r;
  assign odrop_cnt = drop_cnt;

endmodule

// File: doc/mac_hdr_extract.md
Name: mac_hdr_extract

Overview:
- Upstream feeder of the MAC learning/lookup memory.
- Parses the first 12 bytes of each ingress Ethernet frame from a byte-wide stream tagged with ingress port: DA = bytes 0-5, SA = bytes 6-11.
- XOR-folds each 48-bit MAC into a pADDR_WIDTH hash and issues one learn/lookup request per frame.
- Waits for the lookup result and emits it, with a miss flag, to the forwarding stage.

Parameters:
- pNUM_PORTS, 4, number of switch ports; port fields are $clog2(pNUM_PORTS) bits (PW).
- pADDR_WIDTH, 14, hash/memory address width (W).
- pWAIT_MAX, 16, lookup timeout in cycles spent in WAIT.

Ports:
- iclk in 1: clock.
- irst_n in 1: asynchronous active-low reset.
- idata in 8: frame byte; byte 0 is the first octet on the wire.
- ivalid in 1: idata valid.
- isof in 1: first byte of frame (qualified by ivalid).
- ieof in 1: last byte of frame (qualified by ivalid).
- iport in PW: ingress port, sampled with the sof byte.
- opnum out PW: ingress port, to memory.
- osa out W: SA hash.
- oda out W: DA hash.
- owr_en out 1: request strobe, 1 cycle.
- ilk_ready in 1: lookup result valid from memory.
- ilk_pnum in PW: lookup result port.
- olk_valid out 1: result strobe, 1 cycle.
- olk_pnum out PW: looked-up egress port.
- olk_src out PW: ingress port of the frame.
- olk_miss out 1: timeout occurred, no result.
- odrop_cnt out 8: saturating dropped-frame count.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte counter, timer and odrop_cnt cleared. Reset mid-frame abandons that frame and does not count it.
- Hash: h = XOR over k of mac[k*W +: W], with bits above 47 treated as 0. For W=14 the chunks are [13:0], [27:14], [41:28] and the zero-extended [47:42]. The mac is assembled big-endian: byte0 -> [47:40].
- FSM states: IDLE, DA, SA, REQ, WAIT, RESP. Only beats with ivalid=1 are considered.
- IDLE:
  - ivalid & isof: capture byte0 and iport; go to DA.
  - isof & ieof on the same beat: runt; odrop_cnt++; stay in IDLE.
  - Beats without sof are ignored.
- DA / SA:
  - Capture bytes 1-5 in DA, then bytes 6-11 in SA.
  - ieof on any byte before byte 11: runt; odrop_cnt++; go to IDLE.
  - isof on a beat: current frame dropped (odrop_cnt++); restart at byte0 with the new iport, staying in or returning to DA.
  - Byte 11 accepted: go to REQ. ieof together with byte 11 is legal.
- REQ:
  - owr_en=1 for exactly one cycle; osa/oda/opnum are valid in that cycle.
  - owr_en rises the cycle after byte 11 is accepted.
  - Go to WAIT; timer cleared.
- WAIT:
  - opnum/osa/oda held stable.
  - ilk_ready=1: latch ilk_pnum; miss=0; go to RESP.
  - Otherwise, when timer==pWAIT_MAX-1: miss=1, olk_pnum=0; go to RESP.
  - If ilk_ready and timeout coincide, ilk_ready wins.
- RESP: olk_valid=1 for one cycle with olk_pnum/olk_src/olk_miss; go to IDLE.
- After the header is parsed, remaining bytes of the frame are ignored; ieof is not tracked.
- Any ivalid & isof seen while in REQ/WAIT/RESP: frame dropped, odrop_cnt++, its bytes ignored (no input backpressure).
- odrop_cnt saturates at 255.
- Best-case latency from byte 11 to olk_valid: 3 cycles (REQ, WAIT with ilk_ready=1, RESP).

Optional Feature:
- Macro: MAC_HDR_MCAST_SA_DROP_EN.
- Defined: a frame whose SA I/G bit (byte6 bit0) is 1 issues no owr_en. FSM goes SA -> IDLE, odrop_cnt++, no olk_valid.
- Undefined: multicast SA is treated like any other frame.

Test Plan:
- Basic: DA 00:11:22:33:44:55, SA 00:AA:BB:CC:DD:EE, iport=2, 64-byte frame; ilk_ready with ilk_pnum=1 one cycle after owr_en -> oda=0x0D8A; osa equals the model hash; opnum=2; owr_en high 1 cycle; olk_valid with olk_pnum=1, olk_src=2, olk_miss=0, exactly 3 cycles after byte 11.
- Timeout: ilk_ready held low -> olk_valid after 16 WAIT cycles; olk_miss=1; olk_pnum=0.
- Runt: 8-byte frame with ieof on byte 7 -> no owr_en; odrop_cnt=1. Next frame processes normally.
- Busy drop: second sof arrives during WAIT -> second frame gets no owr_en; odrop_cnt increments; the following frame after RESP is processed.
- Reset mid-frame: irst_n low at byte 5 -> all outputs 0 immediately. After release, a full frame yields a correct request.
- Gaps and saturation: ivalid toggled 1/0 through the header -> same hashes as the gap-free case. 300 runts -> odrop_cnt=255.
